// File: rtl/nn_stream_pkg.sv
// Shared helpers for the streaming NN layer stages: signed max and counter widths.
package nn_stream_pkg;

  // Widest sample the shared signed-max helper handles; callers sign-extend into it.
  localparam int SMAX_W = 64;

  // Occupancy type of the two-entry stage buffer.
  typedef logic [1:0] fifo_cnt_t;

  localparam fifo_cnt_t FIFO_EMPTY = 2'd0;
  localparam fifo_cnt_t FIFO_ONE   = 2'd1;
  localparam fifo_cnt_t FIFO_FULL  = 2'd2;

  // Counter width for a range of x values; never returns 0 so x=1 still gets a 1-bit counter.
  function automatic int clog2_min1(input int x);
    return (x < 2) ? 1 : $clog2(x);
  endfunction

  // Signed max; on a tie the first argument wins, so a running max keeps its old value.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/relu_maxpool_1d_fifo2.sv
// stream_fifo2: two-entry valid/ready buffer with registered head and registered
// upstream ready, so the downstream ready never reaches the upstream ready combinationally.
module stream_fifo2
  import nn_stream_pkg::*;
#(
  parameter int T = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  input  logic [T-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [T-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic [1:0]   count_o,
  output logic         full_o
);

  logic [T-1:0] head_q, head_d;
  logic [T-1:0] tail_q, tail_d;
  fifo_cnt_t    count_q, count_d;
  logic         valid_q;
  logic         ready_q;
  logic         push, pop;

  // Next-state for the two slots and occupancy; a push at full only lands if a pop frees a slot.
  always_comb begin
    pop     = out_ready_i && (count_q != FIFO_EMPTY);
    push    = in_valid_i && ((count_q != FIFO_FULL) || pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == FIFO_EMPTY) head_d = in_data_i;
        else                       tail_d = in_data_i;
        count_d = count_q + FIFO_ONE;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - FIFO_ONE;
      end
      2'b11: begin
        if (count_q == FIFO_ONE) begin
          head_d = in_data_i;
        end else begin
          head_d = tail_q;
          tail_d = in_data_i;
        end
      end
      default: ;
    endcase
  end

  // Storage, occupancy and the registered valid/ready flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FIFO_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= (count_d != FIFO_EMPTY);
      ready_q <= (count_d != FIFO_FULL);
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;
  assign count_o     = count_q;
  assign full_o      = (count_q == FIFO_FULL);

endmodule

// File: rtl/relu_maxpool_1d.sv
// relu_maxpool_1d: streaming non-overlapping 1-D max-pool with optional ReLU.
// Each N-element vector yields N/P results; trailing elements that do not fill
// a whole window are accepted and dropped.
module relu_maxpool_1d
  import nn_stream_pkg::*;
#(
  parameter int T    = 16,
  parameter int N    = 57,
  parameter int P    = 2,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_in_y,
  input  logic         s_valid_y,
  output logic         s_ready_y,
  output logic [T-1:0] m_data_out_z,
  output logic         m_valid_z,
  input  logic         m_ready_z
);

  localparam int M  = (P >= 1) ? (N / P) : 0;
  localparam int K  = M * P;
  localparam int EW = clog2_min1(N);
  localparam int WW = clog2_min1(P);

  localparam logic [EW-1:0] ELEM_LAST = EW'(N - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'((P >= 1) ? (P - 1) : 0);
  localparam logic [EW:0]   K_LIM     = (EW + 1)'(K);

  if (P < 1 || P > N) begin : g_bad_pool
    $error("relu_maxpool_1d: pool window P=%0d must lie in 1..N (N=%0d)", P, N);
  end

  logic [EW-1:0]       elem_q, elem_d;
  logic [WW-1:0]       win_q, win_d;
  logic signed [T-1:0] acc_q, acc_d;
  logic signed [T-1:0] sample, cur_max, result;
  logic                in_xfer, push;
  logic                fifo_ready;
  logic [1:0]          fifo_count;
  logic                fifo_full;
  logic                unused_fifo_status;

  // Window max including the current sample, ReLU, and counter advance on each accepted input.
  always_comb begin
    sample  = signed'(s_data_in_y);
    in_xfer = s_valid_y && fifo_ready;
    if (win_q == '0) cur_max = sample;
    else             cur_max = T'(smax(SMAX_W'(acc_q), SMAX_W'(sample)));
    result  = ((RELU != 0) && (cur_max < 0)) ? '0 : cur_max;
    push    = in_xfer && (win_q == WIN_LAST) && ({1'b0, elem_q} < K_LIM);
    elem_d  = elem_q;
    win_d   = win_q;
    acc_d   = acc_q;
    if (in_xfer) begin
      acc_d = cur_max;
      if (elem_q == ELEM_LAST) begin
        elem_d = '0;
        win_d  = '0;
      end else begin
        elem_d = elem_q + EW'(1);
        win_d  = (win_q == WIN_LAST) ? '0 : win_q + WW'(1);
      end
    end
  end

  // Element/window counters and the running max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elem_q <= '0;
      win_q  <= '0;
      acc_q  <= '0;
    end else begin
      elem_q <= elem_d;
      win_q  <= win_d;
      acc_q  <= acc_d;
    end
  end

  stream_fifo2 #(
    .T (T)
  ) u_out_fifo (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (push),
    .in_data_i   (result),
    .in_ready_o  (fifo_ready),
    .out_valid_o (m_valid_z),
    .out_data_o  (m_data_out_z),
    .out_ready_i (m_ready_z),
    .count_o     (fifo_count),
    .full_o      (fifo_full)
  );

  // The upstream ready already encodes the buffer state; count/full are for other stages.
  assign unused_fifo_status = ^{fifo_count, fifo_full};

  assign s_ready_y = fifo_ready;

endmodule

// File: tb/tb_relu_maxpool_1d.sv
// Scoreboard bench for relu_maxpool_1d: three instances (P=2/ReLU, P=2/no ReLU, P=1/ReLU),
// one selected at a time; expected results are computed from stored samples.
module tb_relu_maxpool_1d;

  localparam int NV = 57;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [15:0] s_data = '0;
  logic s_valid = 1'b0;
  logic m_ready = 1'b1;
  int sel = 0;

  logic sv0, sv1, sv2, mr0, mr1, mr2;
  logic r0, r1, r2, v0, v1, v2;
  logic [15:0] d0, d1, d2;
  logic obs_valid, obs_sready;
  logic [15:0] obs_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int out_cnt = 0;
  int fv = -1, lv = -1, x1_edge = -1;

  logic signed [15:0] vec_buf [0:NV-1];
  int mvec [0:NV-1];
  int midx = 0;
  logic [15:0] exp_q [$];
  logic [15:0] e_val;
  int mx, pp;
  bit rl;

  assign sv0 = s_valid && (sel == 0);
  assign sv1 = s_valid && (sel == 1);
  assign sv2 = s_valid && (sel == 2);
  assign mr0 = (sel == 0) ? m_ready : 1'b1;
  assign mr1 = (sel == 1) ? m_ready : 1'b1;
  assign mr2 = (sel == 2) ? m_ready : 1'b1;
  assign obs_valid  = (sel == 0) ? v0 : (sel == 1) ? v1 : v2;
  assign obs_sready = (sel == 0) ? r0 : (sel == 1) ? r1 : r2;
  assign obs_data   = (sel == 0) ? d0 : (sel == 1) ? d1 : d2;

  relu_maxpool_1d #(.T(16), .N(NV), .P(2), .RELU(1)) dut_a (
    .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(sv0), .s_ready_y(r0),
    .m_data_out_z(d0), .m_valid_z(v0), .m_ready_z(mr0));
  relu_maxpool_1d #(.T(16), .N(NV), .P(2), .RELU(0)) dut_b (
    .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(sv1), .s_ready_y(r1),
    .m_data_out_z(d1), .m_valid_z(v1), .m_ready_z(mr1));
  relu_maxpool_1d #(.T(16), .N(NV), .P(1), .RELU(1)) dut_c (
    .clk(clk), .reset(reset), .s_data_in_y(s_data), .s_valid_y(sv2), .s_ready_y(r2),
    .m_data_out_z(d2), .m_valid_z(v2), .m_ready_z(mr2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard: on the falling edge, compare accepted outputs and model accepted inputs.
  always @(negedge clk) begin
    pp = (sel == 2) ? 1 : 2;
    rl = (sel != 1);
    if (reset) begin
      exp_q.delete();
      midx = 0;
    end else begin
      if (obs_valid) begin
        if (fv < 0) fv = cyc;
        lv = cyc;
      end
      if (obs_valid && m_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_extra sel=%0d got=%h expected no output", sel, obs_data);
        end else begin
          e_val = exp_q.pop_front();
          if (obs_data !== e_val) begin
            fails++;
            $display("FAIL sb_data sel=%0d out#%0d got=%h exp=%h", sel, out_cnt, obs_data, e_val);
          end
        end
        out_cnt++;
      end
      if (s_valid && obs_sready) begin
        mvec[midx] = s_data;
        if (midx == 1 && x1_edge < 0) x1_edge = cyc + 1;
        if ((midx % pp) == pp - 1 && midx < (NV / pp) * pp) begin
          mx = mvec[midx];
          for (int j = 1; j < pp; j++) if (mvec[midx - j] > mx) mx = mvec[midx - j];
          if (rl && mx < 0) mx = 0;
          exp_q.push_back(mx[15:0]);
        end
        midx = (midx == NV - 1) ? 0 : midx + 1;
      end
    end
  end

  task automatic drive_vec(input int n, input bit rnd);
    int i = 0;
    int g = 0;
    while (i < n && g < 5000) begin
      s_data  = vec_buf[i];
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (s_valid && obs_sready) i++;
      @(posedge clk); #1;
      g++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tests++;
    if (i != n) begin
      fails++;
      $display("FAIL send_timeout sent=%0d required=%0d", i, n);
    end
  endtask

  task automatic drain(input string name);
    int g = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (exp_q.size() != 0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    tests++; if (obs_sready !== 1'b0) begin fails++; $display("FAIL rst_sready got=%b exp=0", obs_sready); end
    tests++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", obs_valid); end
    tests++; if (obs_data !== 16'h0) begin fails++; $display("FAIL rst_data got=%h exp=0000", obs_data); end
    tests++; if (r2 !== 1'b0) begin fails++; $display("FAIL rst_sready_p1 got=%b exp=0", r2); end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (obs_sready !== 1'b1) begin fails++; $display("FAIL rel_sready got=%b exp=1", obs_sready); end
    tests++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL rel_valid got=%b exp=0", obs_valid); end
  endtask

  task automatic test_basic();
    int base;
    sel = 0;
    for (int i = 0; i < NV; i++) vec_buf[i] = 16'(i - 28);
    fv = -1; x1_edge = -1; base = out_cnt;
    drive_vec(NV, 1'b0);
    drain("basic");
    tests++; if (out_cnt - base != 28) begin fails++; $display("FAIL basic_count got=%0d exp=28", out_cnt - base); end
    tests++;
    if (x1_edge < 0 || fv != x1_edge) begin
      fails++; $display("FAIL basic_latency first_valid_cyc=%0d exp=%0d", fv, x1_edge);
    end
  endtask

  task automatic test_min_value();
    int base;
    for (int i = 0; i < NV; i++) vec_buf[i] = 16'sh8000;
    for (int s = 0; s < 2; s++) begin
      sel = s; base = out_cnt;
      drive_vec(NV, 1'b0);
      drain("minval");
      tests++;
      if (out_cnt - base != 28) begin fails++; $display("FAIL minval_count sel=%0d got=%0d exp=28", s, out_cnt - base); end
    end
    sel = 0;
  endtask

  task automatic test_backpressure();
    int i = 0, c = 0, base;
    bit saw_stall = 0;
    sel = 0; base = out_cnt;
    for (int k = 0; k < NV; k++) vec_buf[k] = 16'(3 * k - 50);
    while (i < NV && c < 500) begin
      s_data = vec_buf[i]; s_valid = 1'b1; m_ready = (c < 10) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (obs_valid && !m_ready && exp_q.size() > 0) begin
        tests++;
        if (obs_data !== exp_q[0]) begin fails++; $display("FAIL bp_hold got=%h exp=%h", obs_data, exp_q[0]); end
      end
      if (!obs_sready && !m_ready && !saw_stall) begin
        saw_stall = 1;
        tests++;
        if (exp_q.size() != 2) begin fails++; $display("FAIL bp_buffered got=%0d exp=2", exp_q.size()); end
      end
      if (s_valid && obs_sready) i++;
      @(posedge clk); #1;
      c++;
    end
    s_valid = 1'b0;
    tests++; if (!saw_stall) begin fails++; $display("FAIL bp_stall got=none exp=s_ready low"); end
    drain("bp");
    tests++; if (out_cnt - base != 28) begin fails++; $display("FAIL bp_count got=%0d exp=28", out_cnt - base); end
  endtask

  task automatic test_random();
    int base;
    sel = 0; base = out_cnt;
    for (int v = 0; v < 156; v++) begin
      for (int i = 0; i < NV; i++) vec_buf[i] = 16'($urandom);
      if (v % 13 == 5) vec_buf[v % NV] = 16'sh8000;
      if (v % 17 == 3) vec_buf[v % NV] = 16'sh7fff;
      drive_vec(NV, 1'b1);
    end
    drain("random");
    tests++; if (out_cnt - base != 4368) begin fails++; $display("FAIL random_count got=%0d exp=4368", out_cnt - base); end
  endtask

  task automatic test_reset_mid();
    int base;
    sel = 0;
    for (int i = 0; i < NV; i++) vec_buf[i] = 16'(i - 10);
    drive_vec(30, 1'b0);
    reset = 1'b1;
    #1;
    tests++; if (obs_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", obs_valid); end
    tests++; if (obs_sready !== 1'b0) begin fails++; $display("FAIL midrst_sready got=%b exp=0", obs_sready); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (obs_sready !== 1'b1) begin fails++; $display("FAIL midrst_rel_sready got=%b exp=1", obs_sready); end
    for (int i = 0; i < NV; i++) vec_buf[i] = 16'(40 - 2 * i + ((i % 3) * 7));
    base = out_cnt;
    drive_vec(NV, 1'b0);
    drain("midrst");
    tests++; if (out_cnt - base != 28) begin fails++; $display("FAIL midrst_count got=%0d exp=28", out_cnt - base); end
  endtask

  task automatic test_p1();
    int base;
    sel = 2;
    for (int i = 0; i < NV; i++) vec_buf[i] = 16'(i - 28);
    fv = -1; lv = -1; base = out_cnt;
    drive_vec(NV, 1'b0);
    drain("p1");
    tests++; if (out_cnt - base != NV) begin fails++; $display("FAIL p1_count got=%0d exp=%0d", out_cnt - base, NV); end
    tests++; if (lv - fv + 1 != NV) begin fails++; $display("FAIL p1_bubbles span=%0d exp=%0d", lv - fv + 1, NV); end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_value();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_p1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
